lc3_control_fsm: RTL
====================

// Module: lc3_control_fsm
// PURPOSE
//  Instruction-sequencing state machine (ISDU) for the 16-bit LC-3 datapath.
//  Decodes IR opcode/flag bits and BEN; drives every LD_*, Gate*, mux select and SRAM strobe.
//  Runs fetch -> decode -> execute with a programmable SRAM wait; sits beside the datapath in the CPU top.
// PARAMETERS
//  MEM_WAIT  2  cycles each SRAM read/write state is held (1..15)
// PORTS
//  Clk        in   1  system clock, rising edge
//  Reset      in   1  asynchronous, active-high; forces HALTED
//  Run        in   1  start pulse, sampled in HALTED
//  Continue   in   1  resume strobe for PAUSE
//  Opcode     in   4  IR[15:12]
//  IR_5       in   1  IR[5], immediate select for ADD/AND
//  IR_11      in   1  IR[11], JSR vs JSRR
//  BEN        in   1  branch enable from datapath
//  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out 1 each  register loads
//  GatePC, GateMDR, GateALU, GateMARMUX  out 1 each  bus drivers; at most one high per cycle
//  PCMUX      out  2  00 PC+1, 01 bus, 10 address adder
//  DRMUX, SR1MUX, SR2MUX, ADDR1MUX  out 1 each  datapath selects
//  ADDR2MUX   out  2  00 zero, 01 off6, 10 off9, 11 off11
//  ALUK       out  2  00 ADD, 01 AND, 10 NOT, 11 PASS
//  MIO_EN     out  1  MDR loads from SRAM when high
//  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out 1 each  active-low SRAM strobes
// BEHAVIOUR
//  - Reset (async): state=HALTED, wait counter=0, all LD_*/Gate*/MIO_EN=0, selects=0, Mem_*=1.
//  - All outputs are a combinational decode of the current state (Moore); no output depends on Run/Continue.
//  - HALTED: Run=1 -> S18; otherwise hold.
//  - Fetch: S18 GatePC,LD_MAR,PCMUX=00,LD_PC -> S33 (Mem_CE/OE low, MIO_EN, LD_MDR) -> S35 GateMDR,LD_IR -> S32.
//  - S32: LD_BEN; branch on Opcode: 0001 ADD, 0101 AND, 1001 NOT, 0000 BR, 1100 JMP, 0100 JSR,
//    0110 LDR, 0111 STR, 1101 PAUSE; any other opcode -> S18 (NOP).
//  - ADD/AND: SR2MUX=IR_5, GateALU, LD_REG, LD_CC -> S18. NOT: ALUK=10, same loads -> S18.
//  - BR: S0 -> S22 (ADDR2MUX=10, PCMUX=10, LD_PC) if BEN else S18; S22 -> S18.
//  - JMP: ADDR1MUX=1, ADDR2MUX=00, PCMUX=10, LD_PC -> S18.
//  - JSR: S4 GatePC,DRMUX=1 (R7),LD_REG -> S21 (IR_11: ADDR2MUX=11 PC-rel; else base reg) LD_PC -> S18.
//  - LDR: S6 MAR<-base+off6 -> S25 read -> S27 GateMDR,LD_REG,LD_CC -> S18.
//  - STR: S7 MAR<-base+off6 -> S23 MDR<-SR (MIO_EN=0) -> S16 write (Mem_CE/WE low) -> S18.
//  - Memory states S33/S25/S16 hold exactly MEM_WAIT cycles; counter clears on entry, advances at MEM_WAIT-1.
//  - Mem_WE low only inside S16; never concurrently with Mem_OE low.
//  - Reset mid-access: immediate HALTED, strobes high same cycle (async).
//  - Mem_UB/Mem_LB low whenever Mem_CE low (16-bit access only).
// CONFIGURATION
//  LC3_PAUSE_EN defined: opcode 1101 -> PAUSE_IR1 (LD_LED=1) waits Continue=1 -> PAUSE_IR2
//    waits Continue=0 -> S18 (full high-low handshake, one instruction per press).
//  LC3_PAUSE_EN undefined: 1101 is an unrecognised opcode -> S18; LD_LED is tied 0; PAUSE states absent.
// STRUCTURE
//  lc3_pkg: state_t enum, opcode localparams, PCMUX/ADDR2MUX/ALUK encodings, MEM_WAIT bounds.
//  Sub-module mem_wait_counter (start, done, MEM_WAIT param); FSM instantiates one copy.
// TESTING
//  1 Reset during S33 with MEM_WAIT=2 -> same cycle state=HALTED, Mem_CE=Mem_OE=1, LD_*=0.
//  2 Run pulse, Opcode=0001 IR_5=1 -> S18,S33,S33,S35,S32,ADD; LD_REG=LD_CC=1, SR2MUX=1 in ADD; 6 cycles total.
//  3 Opcode=0000 BEN=0 -> S32,S0,S18 with no LD_PC in S0; BEN=1 -> S22 asserts LD_PC, PCMUX=10.
//  4 Opcode=0111 MEM_WAIT=3 -> Mem_WE low exactly 3 cycles in S16, Mem_OE high throughout.
//  5 LC3_PAUSE_EN, Opcode=1101 -> LD_LED=1; holds until Continue 1 then 0, then S18.
//  6 Opcode=1010 (illegal) -> S32 to S18 next cycle; no LD_REG/LD_PC/Mem strobes.

Source files
------------

// File: rtl/lc3_control_fsm_pkg.sv
// Shared types and encodings for the LC-3 instruction-sequencing FSM.
// The PAUSE states exist only when LC3_PAUSE_EN is defined.
package lc3_control_fsm_pkg;

    localparam int MEM_WAIT_MIN = 1;
    localparam int MEM_WAIT_MAX = 15;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] PCMUX_PC1   = 2'b00;
    localparam logic [1:0] PCMUX_BUS   = 2'b01;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    localparam logic [1:0] ALUK_ADD  = 2'b00;
    localparam logic [1:0] ALUK_AND  = 2'b01;
    localparam logic [1:0] ALUK_NOT  = 2'b10;
    localparam logic [1:0] ALUK_PASS = 2'b11;

    typedef enum logic [4:0] {
        HALTED,
        S18, S33, S35, S32,
        S1, S5, S9,
        S0, S22,
        S12,
        S4, S21,
        S6, S25, S27,
        S7, S23, S16
`ifdef LC3_PAUSE_EN
        , PAUSE_IR1, PAUSE_IR2
`endif
    } state_t;

    typedef struct packed {
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_ben;
        logic       ld_cc;
        logic       ld_reg;
        logic       ld_pc;
        logic       ld_led;
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic [1:0] pcmux;
        logic       drmux;
        logic       sr1mux;
        logic       sr2mux;
        logic       addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       mio_en;
        logic       mem_ce;
        logic       mem_ub;
        logic       mem_lb;
        logic       mem_oe;
        logic       mem_we;
    } ctrl_t;

    // Idle: nothing loads, nothing drives the bus, SRAM deselected.
    localparam ctrl_t CTRL_IDLE = '{mem_ce: 1'b1, mem_ub: 1'b1, mem_lb: 1'b1,
                                    mem_oe: 1'b1, mem_we: 1'b1, default: '0};

    function automatic logic is_mem_state(input state_t s);
        return (s == S33) || (s == S25) || (s == S16);
    endfunction

    // SR1MUX=1 selects IR[8:6] (SR1/BaseR); 0 selects IR[11:9] (SR for STR).
    function automatic ctrl_t state_ctrl(input state_t s, input logic ir5, input logic ir11);
        ctrl_t c;
        c = CTRL_IDLE;
        case (s)
            S18: begin
                c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.pcmux = PCMUX_PC1; c.ld_pc = 1'b1;
            end
            S33, S25: begin
                c.mem_ce = 1'b0; c.mem_ub = 1'b0; c.mem_lb = 1'b0; c.mem_oe = 1'b0;
                c.mio_en = 1'b1; c.ld_mdr = 1'b1;
            end
            S35: begin c.gate_mdr = 1'b1; c.ld_ir = 1'b1; end
            S32: c.ld_ben = 1'b1;
            S1, S5: begin
                c.sr1mux = 1'b1; c.sr2mux = ir5;
                c.aluk = (s == S1) ? ALUK_ADD : ALUK_AND;
                c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
            end
            S9: begin
                c.sr1mux = 1'b1; c.aluk = ALUK_NOT;
                c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
            end
            S22: begin c.addr2mux = ADDR2_OFF9; c.pcmux = PCMUX_ADDER; c.ld_pc = 1'b1; end
            S12: begin
                c.sr1mux = 1'b1; c.addr1mux = 1'b1; c.addr2mux = ADDR2_ZERO;
                c.pcmux = PCMUX_ADDER; c.ld_pc = 1'b1;
            end
            S4: begin c.gate_pc = 1'b1; c.drmux = 1'b1; c.ld_reg = 1'b1; end
            S21: begin
                if (ir11) begin
                    c.addr2mux = ADDR2_OFF11;
                end else begin
                    c.sr1mux = 1'b1; c.addr1mux = 1'b1; c.addr2mux = ADDR2_ZERO;
                end
                c.pcmux = PCMUX_ADDER; c.ld_pc = 1'b1;
            end
            S6, S7: begin
                c.sr1mux = 1'b1; c.addr1mux = 1'b1; c.addr2mux = ADDR2_OFF6;
                c.gate_marmux = 1'b1; c.ld_mar = 1'b1;
            end
            S27: begin c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; end
            S23: begin c.aluk = ALUK_PASS; c.gate_alu = 1'b1; c.ld_mdr = 1'b1; end
            S16: begin c.mem_ce = 1'b0; c.mem_ub = 1'b0; c.mem_lb = 1'b0; c.mem_we = 1'b0; end
`ifdef LC3_PAUSE_EN
            PAUSE_IR1: c.ld_led = 1'b1;
`endif
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lc3_control_fsm_if.sv
// Control/status bundle between the LC-3 sequencer (master) and the datapath (slave).
interface lc3_control_fsm_if;
    logic       Run, Continue;
    logic [3:0] Opcode;
    logic       IR_5, IR_11, BEN;

    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX;
    logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
    logic [1:0] ADDR2MUX, ALUK;
    logic       MIO_EN;
    logic       Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

    modport master (
        input  Run, Continue, Opcode, IR_5, IR_11, BEN,
        output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
               GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX, SR2MUX,
               ADDR1MUX, ADDR2MUX, ALUK, MIO_EN, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
    );

    modport slave (
        output Run, Continue, Opcode, IR_5, IR_11, BEN,
        input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
               GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX, SR2MUX,
               ADDR1MUX, ADDR2MUX, ALUK, MIO_EN, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
    );
endinterface

// File: rtl/lc3_control_fsm_mem_wait_counter.sv
// Dwell counter for SRAM access states: cleared on entry, done on the MEM_WAIT-th cycle.
module mem_wait_counter #(
    parameter int MEM_WAIT = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic busy_i,
    output logic done_o
);
    logic [3:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (start_i) begin
            cnt_q <= '0;
        end else if (busy_i && !done_o) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    assign done_o = (cnt_q == 4'(MEM_WAIT - 1));
endmodule

// File: rtl/lc3_control_fsm.sv
// LC-3 ISDU: fetch/decode/execute sequencer with registered Moore outputs.
// Optional PAUSE instruction support is enabled by defining LC3_PAUSE_EN.
module lc3_control_fsm
    import lc3_control_fsm_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    lc3_control_fsm_if.master ctl,
    output state_t            state_o
);
    state_t state_q, state_d;
    ctrl_t  ctrl_q;
    logic   mem_done, mem_start, mem_busy;

    assign mem_busy  = is_mem_state(state_q);
    assign mem_start = is_mem_state(state_d) && !mem_busy;

    mem_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .start_i (mem_start),
        .busy_i  (mem_busy),
        .done_o  (mem_done)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            HALTED: if (ctl.Run) state_d = S18;
            S18:    state_d = S33;
            S33:    if (mem_done) state_d = S35;
            S35:    state_d = S32;
            S32: begin
                case (ctl.Opcode)
                    OP_ADD:   state_d = S1;
                    OP_AND:   state_d = S5;
                    OP_NOT:   state_d = S9;
                    OP_BR:    state_d = S0;
                    OP_JMP:   state_d = S12;
                    OP_JSR:   state_d = S4;
                    OP_LDR:   state_d = S6;
                    OP_STR:   state_d = S7;
`ifdef LC3_PAUSE_EN
                    OP_PAUSE: state_d = PAUSE_IR1;
`endif
                    default:  state_d = S18;
                endcase
            end
            S0:     state_d = ctl.BEN ? S22 : S18;
            S4:     state_d = S21;
            S6:     state_d = S25;
            S25:    if (mem_done) state_d = S27;
            S7:     state_d = S23;
            S23:    state_d = S16;
            S16:    if (mem_done) state_d = S18;
`ifdef LC3_PAUSE_EN
            // Full press/release handshake so one press advances one instruction.
            PAUSE_IR1: if (ctl.Continue) state_d = PAUSE_IR2;
            PAUSE_IR2: if (!ctl.Continue) state_d = S18;
`endif
            default: state_d = S18;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it,
    // so they always match state_q and reset drops them asynchronously.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= HALTED;
            ctrl_q  <= CTRL_IDLE;
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d, ctl.IR_5, ctl.IR_11);
        end
    end

`ifdef LC3_PAUSE_EN
    assign ctl.LD_LED = ctrl_q.ld_led;
`else
    logic unused_pause;
    assign unused_pause = ctl.Continue ^ ctrl_q.ld_led;
    assign ctl.LD_LED   = 1'b0;
`endif

    assign state_o        = state_q;
    assign ctl.LD_MAR     = ctrl_q.ld_mar;
    assign ctl.LD_MDR     = ctrl_q.ld_mdr;
    assign ctl.LD_IR      = ctrl_q.ld_ir;
    assign ctl.LD_BEN     = ctrl_q.ld_ben;
    assign ctl.LD_CC      = ctrl_q.ld_cc;
    assign ctl.LD_REG     = ctrl_q.ld_reg;
    assign ctl.LD_PC      = ctrl_q.ld_pc;
    assign ctl.GatePC     = ctrl_q.gate_pc;
    assign ctl.GateMDR    = ctrl_q.gate_mdr;
    assign ctl.GateALU    = ctrl_q.gate_alu;
    assign ctl.GateMARMUX = ctrl_q.gate_marmux;
    assign ctl.PCMUX      = ctrl_q.pcmux;
    assign ctl.DRMUX      = ctrl_q.drmux;
    assign ctl.SR1MUX     = ctrl_q.sr1mux;
    assign ctl.SR2MUX     = ctrl_q.sr2mux;
    assign ctl.ADDR1MUX   = ctrl_q.addr1mux;
    assign ctl.ADDR2MUX   = ctrl_q.addr2mux;
    assign ctl.ALUK       = ctrl_q.aluk;
    assign ctl.MIO_EN     = ctrl_q.mio_en;
    assign ctl.Mem_CE     = ctrl_q.mem_ce;
    assign ctl.Mem_UB     = ctrl_q.mem_ub;
    assign ctl.Mem_LB     = ctrl_q.mem_lb;
    assign ctl.Mem_OE     = ctrl_q.mem_oe;
    assign ctl.Mem_WE     = ctrl_q.mem_we;
endmodule
